// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared sizes and the fetch FSM state encoding
package fetch_unit_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_MEM_SIZE = 256;
  localparam int DEF_ADDR_BITS = $clog2(DEF_MEM_SIZE);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg: program counter with redirect load and wrapping increment (clk, reset, i_load/i_target, i_inc -> o_pc)
module fetch_unit_pc_reg #(
  parameter int ADDR_BITS = 8,
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [ADDR_BITS-1:0] i_target,
  input  logic                 i_inc,
  output logic [ADDR_BITS-1:0] o_pc
);
  logic [ADDR_BITS-1:0] r_pc;
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_target;
    else if (i_inc) r_pc <= r_pc + ADDR_BITS'(1);
  end
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with run/halt FSM, valid/ready handoff to decode, redirect flush and saturating fetch count
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] pointer,
  input  logic [WORD_SIZE-1:0] instr_in,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  output logic                 running,
  output logic [WORD_SIZE-1:0] fetch_count
);
  state_t r_state, w_state_next;
  logic [WORD_SIZE-1:0] r_ir, r_ipc, r_count;
  logic r_valid, w_xfer, w_load, w_fetch;
  logic [ADDR_BITS-1:0] w_pc;
  logic w_unused;
  assign w_unused = &{1'b0, redirect_target};
  assign w_xfer = r_valid & instr_ready;
  assign w_load = !r_valid | instr_ready;
  fetch_unit_pc_reg #(
    .ADDR_BITS(ADDR_BITS),
    .RESET_PC (ADDR_BITS'(RESET_PC))
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .i_load  (redirect),
    .i_target(redirect_target[ADDR_BITS-1:0]),
    .i_inc   (w_fetch),
    .o_pc    (w_pc)
  );
  always_comb begin
    w_state_next = IDLE;
    w_fetch = 1'b0;
    if (redirect) w_state_next = (r_state == DRAIN) ? IDLE : r_state;
    else if (r_state == IDLE) w_state_next = start ? RUN : IDLE;
    else if (r_state == RUN) begin
      w_state_next = halt ? DRAIN : RUN;
      w_fetch = !halt && w_load;
    end
    else if (r_state == DRAIN) w_state_next = (!r_valid || w_xfer) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ir <= '0;
      r_ipc <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect) r_valid <= 1'b0;
      else if (w_fetch) begin
        r_valid <= 1'b1;
        r_ir <= instr_in;
        r_ipc <= WORD_SIZE'(w_pc);
      end
      else if (w_xfer) r_valid <= 1'b0;
      if (w_xfer && !redirect && r_count != '1) r_count <= r_count + WORD_SIZE'(1);
    end
  end
  assign pointer = WORD_SIZE'(w_pc);
  assign instr_out = r_ir;
  assign instr_pc = r_ipc;
  assign instr_valid = r_valid;
  assign running = (r_state == RUN) || (r_state == DRAIN);
  assign fetch_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, reset = 1, start = 0, halt = 0, instr_ready = 0, redirect = 0;
  logic [15:0] redirect_target = '0, pointer, instr_in, instr_out, instr_pc, fetch_count;
  logic instr_valid, running;
  logic reset2 = 1, start2 = 0, ready2 = 0;
  logic [7:0] pointer2, instr_out2, instr_pc2, fetch_count2;
  logic valid2, running2;
  int checks = 0, errors = 0;
  logic [65:0] obs;
  logic [33:0] sub;
  always #5 clk = ~clk;
  function automatic logic [15:0] mem(input logic [15:0] a);
    return {~a[7:0], a[7:0]};
  endfunction
  assign instr_in = mem(pointer);
  assign obs = {instr_out, instr_pc, pointer, fetch_count, instr_valid, running};
  assign sub = {pointer, fetch_count, instr_valid, running};
  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pointer(pointer),
    .instr_in(instr_in), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .running(running), .fetch_count(fetch_count)
  );
  fetch_unit #(.WORD_SIZE(8), .ADDR_BITS(4)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .halt(1'b0), .pointer(pointer2),
    .instr_in({pointer2[3:0], 4'hA}), .instr_out(instr_out2), .instr_pc(instr_pc2),
    .instr_valid(valid2), .instr_ready(ready2), .redirect(1'b0),
    .redirect_target(8'h00), .running(running2), .fetch_count(fetch_count2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [65:0] e;
    tick();
    tick();
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset got %h exp %h", obs, e); end
  endtask
  task automatic test_stream();
    logic [65:0] e;
    reset = 0; start = 1; instr_ready = 1;
    tick();
    start = 0;
    e = {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL start_bubble got %h exp %h", obs, e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      e = {mem(16'(i)), 16'(i), 16'(i + 1), 16'(i), 1'b1, 1'b1};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stream%0d got %h exp %h", i, obs, e); end
    end
  endtask
  task automatic test_stall();
    logic [65:0] e;
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = {mem(16'd4), 16'd4, 16'd5, 16'd4, 1'b1, 1'b1};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stall%0d got %h exp %h", i, obs, e); end
    end
    instr_ready = 1;
    tick();
    e = {mem(16'd5), 16'd5, 16'd6, 16'd5, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL stall_release got %h exp %h", obs, e); end
  endtask
  task automatic test_redirect();
    logic [65:0] e;
    logic [33:0] s;
    redirect = 1; redirect_target = 16'h0013;
    tick();
    redirect = 0;
    s = {16'h0013, 16'd5, 1'b0, 1'b1};
    checks++;
    if (sub !== s) begin errors++; $display("FAIL redirect_flush got %h exp %h", sub, s); end
    tick();
    e = {mem(16'h13), 16'h0013, 16'h0014, 16'd5, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL redirect_target got %h exp %h", obs, e); end
  endtask
  task automatic test_wrap();
    logic [65:0] e;
    logic [33:0] s;
    redirect = 1; redirect_target = 16'h12FF;
    tick();
    redirect = 0;
    s = {16'h00FF, 16'd5, 1'b0, 1'b1};
    checks++;
    if (sub !== s) begin errors++; $display("FAIL wrap_load got %h exp %h", sub, s); end
    tick();
    e = {mem(16'hFF), 16'h00FF, 16'h0000, 16'd5, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wrap_ff got %h exp %h", obs, e); end
    tick();
    e = {mem(16'h0), 16'h0000, 16'h0001, 16'd6, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL wrap_zero got %h exp %h", obs, e); end
  endtask
  task automatic test_halt();
    logic [65:0] e;
    logic [33:0] s;
    instr_ready = 0; halt = 1;
    tick();
    e = {mem(16'h0), 16'h0000, 16'h0001, 16'd6, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL drain_enter got %h exp %h", obs, e); end
    halt = 0;
    tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL drain_hold got %h exp %h", obs, e); end
    instr_ready = 1;
    tick();
    s = {16'h0001, 16'd7, 1'b0, 1'b0};
    checks++;
    if (sub !== s) begin errors++; $display("FAIL drain_exit got %h exp %h", sub, s); end
    tick();
    checks++;
    if (sub !== s) begin errors++; $display("FAIL idle_hold got %h exp %h", sub, s); end
    start = 1;
    tick();
    start = 0;
    s = {16'h0001, 16'd7, 1'b0, 1'b1};
    checks++;
    if (sub !== s) begin errors++; $display("FAIL resume_bubble got %h exp %h", sub, s); end
    tick();
    e = {mem(16'h1), 16'h0001, 16'h0002, 16'd7, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL resume_fetch got %h exp %h", obs, e); end
  endtask
  task automatic test_reset_mid();
    logic [65:0] e;
    instr_ready = 0;
    tick();
    e = {mem(16'h1), 16'h0001, 16'h0002, 16'd7, 1'b1, 1'b1};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL pre_reset_stall got %h exp %h", obs, e); end
    reset = 1; redirect = 1; redirect_target = 16'h0040;
    tick();
    reset = 0; redirect = 0;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_reset got %h exp %h", obs, e); end
    tick();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_idle got %h exp %h", obs, e); end
  endtask
  task automatic test_saturate();
    tick();
    reset2 = 0; start2 = 1; ready2 = 1;
    repeat (256) tick();
    checks++;
    if (fetch_count2 !== 8'hFE) begin errors++; $display("FAIL sat_near got %h exp fe", fetch_count2); end
    repeat (44) tick();
    checks++;
    if (fetch_count2 !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h exp ff", fetch_count2); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
